// File: rtl/synth_pkg.sv
// Shared constants and record types for the voice synthesis datapath.
// The scheduler and its helpers import this package.
package synth_pkg;

  localparam int NUM_VOICES = 48;
  localparam int FRAME_LEN  = 667;
  localparam int NOTE_W     = 7;
  localparam int VOICE_W    = $clog2(NUM_VOICES);

  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] note;
  } voice_entry_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
  } midi_cmd_t;

endpackage

// File: rtl/voice_alloc_pe.sv
// Lowest-index priority encoder over a request vector.
// Returns whether any bit is set and the index of the lowest set bit.
module voice_alloc_pe #(
  parameter int N = 48,
  parameter int W = 6
) (
  input  logic [N-1:0] i_req,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_slot_scheduler.sv
// Frame sequencer for the shared voice datapath and owner of the voice table.
// Slots are issued at the start of each frame; commands land only in the idle window.
module voice_slot_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int FRAME_LEN  = synth_pkg::FRAME_LEN,
  parameter int NOTE_W     = synth_pkg::NOTE_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_on,
  input  logic [NOTE_W-1:0]               cmd_note,
  output logic                            frame_start,
  output logic                            slot_valid,
  output logic [$clog2(NUM_VOICES)-1:0]   slot_voice,
  output logic [NOTE_W-1:0]               slot_note,
  output logic                            slot_active,
  output logic [$clog2(NUM_VOICES+1)-1:0] active_count,
  output logic                            alloc_fail
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int VW    = $clog2(NUM_VOICES);
  localparam int CW    = $clog2(NUM_VOICES + 1);

  logic [CNT_W-1:0] r_cnt;
  voice_entry_t     r_table [NUM_VOICES];
  logic             r_frame_start;
  logic             r_slot_valid;
  logic [VW-1:0]    r_slot_voice;
  logic [NOTE_W-1:0] r_slot_note;
  logic             r_slot_active;
  logic [CW-1:0]    r_active_count;
  logic             r_alloc_fail;

  logic [NUM_VOICES-1:0] w_free_req;
  logic [NUM_VOICES-1:0] w_match_req;
  logic                  w_free_found;
  logic                  w_match_found;
  logic [VW-1:0]         w_free_idx;
  logic [VW-1:0]         w_match_idx;
  logic [CW-1:0]         w_match_cnt;
  logic                  w_in_slot;
  logic                  w_accept;
  logic [VW-1:0]         w_slot_idx;
  voice_entry_t          w_slot_entry;
  midi_cmd_t             w_cmd;

  assign w_in_slot  = (r_cnt < CNT_W'(NUM_VOICES));
  assign cmd_ready  = ~w_in_slot;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_cmd      = '{on: cmd_on, note: cmd_note};
  assign w_slot_idx = r_cnt[VW-1:0];
  assign w_slot_entry = w_in_slot ? r_table[w_slot_idx] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_req
      assign w_free_req[gi]  = ~r_table[gi].active;
      assign w_match_req[gi] = r_table[gi].active & (r_table[gi].note == w_cmd.note);
    end
  endgenerate

  always_comb begin
    w_match_cnt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_match_cnt = w_match_cnt + CW'(w_match_req[i]);
    end
  end

  voice_alloc_pe #(.N(NUM_VOICES), .W(VW)) u_free_pe (
    .i_req   (w_free_req),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  voice_alloc_pe #(.N(NUM_VOICES), .W(VW)) u_match_pe (
    .i_req   (w_match_req),
    .o_found (w_match_found),
    .o_idx   (w_match_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_frame_start  <= 1'b0;
      r_slot_valid   <= 1'b0;
      r_slot_voice   <= '0;
      r_slot_note    <= '0;
      r_slot_active  <= 1'b0;
      r_active_count <= '0;
      r_alloc_fail   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      r_cnt         <= (r_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : r_cnt + 1'b1;
      r_frame_start <= (r_cnt == '0);
      r_slot_valid  <= w_in_slot;
      r_slot_voice  <= w_in_slot ? w_slot_idx : '0;
      r_slot_note   <= w_slot_entry.note;
      r_slot_active <= w_slot_entry.active;
      r_alloc_fail  <= 1'b0;
      // Accepts only happen outside the slot window, so slot reads never race a write.
      if (w_accept) begin
        if (w_cmd.on) begin
          if (!w_match_found) begin
            if (w_free_found) begin
              r_table[w_free_idx] <= '{active: 1'b1, note: w_cmd.note};
              r_active_count      <= r_active_count + 1'b1;
            end else begin
              r_alloc_fail <= 1'b1;
            end
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_match_req[i]) begin
              r_table[i].active <= 1'b0;
            end
          end
          r_active_count <= r_active_count - w_match_cnt;
        end
      end
    end
  end

  assign frame_start  = r_frame_start;
  assign slot_valid   = r_slot_valid;
  assign slot_voice   = r_slot_voice;
  assign slot_note    = r_slot_note;
  assign slot_active  = r_slot_active;
  assign active_count = r_active_count;
  assign alloc_fail   = r_alloc_fail;

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Directed bench for voice_slot_scheduler: frame timing vectors plus
// hand-written allocation, full-table and mid-frame reset sequences.
module tb_voice_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_on = 1'b0;
  logic [6:0] cmd_note = '0;
  logic       frame_start;
  logic       slot_valid;
  logic [5:0] slot_voice;
  logic [6:0] slot_note;
  logic       slot_active;
  logic [5:0] active_count;
  logic       alloc_fail;

  voice_slot_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_on       (cmd_on),
    .cmd_note     (cmd_note),
    .frame_start  (frame_start),
    .slot_valid   (slot_valid),
    .slot_voice   (slot_voice),
    .slot_note    (slot_note),
    .slot_active  (slot_active),
    .active_count (active_count),
    .alloc_fail   (alloc_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic fs;
    logic sv;
    int   voice;
    logic rdy;
  } vec_t;

  int cyc;
  int errors;
  int checks;
  int fs_cyc;
  int fr_note [48];
  int fr_act  [48];
  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got 0, expected 1", nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while ((cyc % 667) != c && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeout("wait_cnt");
  endtask

  task automatic send_cmd(input logic on, input int note, input int exp_fail,
                          input int exp_cnt, input string nm);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeout({nm, " ready"});
    cmd_valid = 1'b1;
    cmd_on    = on;
    cmd_note  = 7'(note);
    tick();
    cmd_valid = 1'b0;
    chk({nm, " alloc_fail"}, int'(alloc_fail), exp_fail);
    chk({nm, " active_count"}, int'(active_count), exp_cnt);
    $display("cmd %s on=%0d note=%0d alloc_fail=%0d active_count=%0d",
             nm, on, note, alloc_fail, active_count);
  endtask

  task automatic capture_frame();
    int n;
    n = 0;
    while (!frame_start && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeout("frame_start");
    fs_cyc = cyc;
    for (int s = 0; s < 48; s++) begin
      fr_note[s] = int'(slot_note);
      fr_act[s]  = int'(slot_active);
      if (s < 47) tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;

    // Reset state while rst_n is held low.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst frame_start", int'(frame_start), 0);
    chk("rst slot_valid", int'(slot_valid), 0);
    chk("rst slot_voice", int'(slot_voice), 0);
    chk("rst active_count", int'(active_count), 0);
    chk("rst alloc_fail", int'(alloc_fail), 0);
    chk("rst cmd_ready", int'(cmd_ready), 0);

    vecs[0] = '{cyc: 0,   fs: 0, sv: 0, voice: 0,  rdy: 0};
    vecs[1] = '{cyc: 1,   fs: 1, sv: 1, voice: 0,  rdy: 0};
    vecs[2] = '{cyc: 2,   fs: 0, sv: 1, voice: 1,  rdy: 0};
    vecs[3] = '{cyc: 47,  fs: 0, sv: 1, voice: 46, rdy: 0};
    vecs[4] = '{cyc: 48,  fs: 0, sv: 1, voice: 47, rdy: 1};
    vecs[5] = '{cyc: 49,  fs: 0, sv: 0, voice: 0,  rdy: 1};
    vecs[6] = '{cyc: 666, fs: 0, sv: 0, voice: 0,  rdy: 1};
    vecs[7] = '{cyc: 667, fs: 0, sv: 0, voice: 0,  rdy: 0};
    vecs[8] = '{cyc: 668, fs: 1, sv: 1, voice: 0,  rdy: 0};
    vecs[9] = '{cyc: 669, fs: 0, sv: 1, voice: 1,  rdy: 0};

    repeat (1) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int v = 0; v < 10; v++) begin
      while (cyc < vecs[v].cyc) tick();
      chk($sformatf("vec%0d frame_start", v), int'(frame_start), int'(vecs[v].fs));
      chk($sformatf("vec%0d slot_valid", v), int'(slot_valid), int'(vecs[v].sv));
      if (vecs[v].sv) begin
        chk($sformatf("vec%0d slot_voice", v), int'(slot_voice), vecs[v].voice);
        chk($sformatf("vec%0d slot_active", v), int'(slot_active), 0);
      end
      chk($sformatf("vec%0d cmd_ready", v), int'(cmd_ready), int'(vecs[v].rdy));
      $display("vec %0d cyc=%0d fs=%0d sv=%0d voice=%0d rdy=%0d",
               v, cyc, frame_start, slot_valid, slot_voice, cmd_ready);
    end

    // cmd_valid held from cnt=10: the first accept must be at cnt=48.
    wait_cnt(10);
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    cmd_note  = 7'd60;
    begin
      int n;
      n = 0;
      while (!cmd_ready && n < 2000) begin
        chk("hold no early accept", int'(active_count), 0);
        tick();
        n++;
      end
      if (n >= 2000) timeout("hold ready");
    end
    chk("hold accept cnt", cyc % 667, 48);
    tick();
    cmd_valid = 1'b0;
    chk("hold alloc_fail", int'(alloc_fail), 0);
    chk("hold active_count", int'(active_count), 1);
    $display("hold accepted at cnt=48 active_count=%0d", active_count);

    send_cmd(1'b1, 64, 0, 2, "on64");
    send_cmd(1'b1, 60, 0, 2, "on60 retrigger");
    capture_frame();
    chk("f1 v0 note", fr_note[0], 60);
    chk("f1 v0 act", fr_act[0], 1);
    chk("f1 v1 note", fr_note[1], 64);
    chk("f1 v1 act", fr_act[1], 1);
    chk("f1 v2 act", fr_act[2], 0);

    send_cmd(1'b0, 60, 0, 1, "off60");
    send_cmd(1'b1, 72, 0, 2, "on72");
    send_cmd(1'b0, 99, 0, 2, "off99 nomatch");
    capture_frame();
    chk("f2 v0 note", fr_note[0], 72);
    chk("f2 v0 act", fr_act[0], 1);
    chk("f2 v1 note", fr_note[1], 64);
    chk("f2 v1 act", fr_act[1], 1);
    chk("f2 v2 act", fr_act[2], 0);

    for (int n = 0; n < 46; n++) begin
      send_cmd(1'b1, n, 0, n + 3, $sformatf("fill%0d", n));
    end
    send_cmd(1'b1, 100, 1, 48, "on100 full");
    tick();
    chk("alloc_fail one cycle", int'(alloc_fail), 0);
    chk("full count holds", int'(active_count), 48);
    capture_frame();
    for (int s = 0; s < 48; s++) begin
      int exp_note;
      exp_note = (s == 0) ? 72 : (s == 1) ? 64 : s - 2;
      chk($sformatf("full v%0d note", s), fr_note[s], exp_note);
      chk($sformatf("full v%0d act", s), fr_act[s], 1);
    end

    // Reset asserted mid-frame with five voices sounding.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      send_cmd(1'b1, 10 + n, 0, n + 1, $sformatf("pre%0d", n));
    end
    wait_cnt(20);
    chk("pre-reset slot_valid", int'(slot_valid), 1);
    chk("pre-reset slot_voice", int'(slot_voice), 19);
    #2 rst_n = 1'b0;
    #1;
    chk("async slot_valid", int'(slot_valid), 0);
    chk("async slot_voice", int'(slot_voice), 0);
    chk("async active_count", int'(active_count), 0);
    chk("async frame_start", int'(frame_start), 0);
    chk("async cmd_ready", int'(cmd_ready), 0);
    $display("async reset slot_valid=%0d active_count=%0d", slot_valid, active_count);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    capture_frame();
    chk("restart fs cycle", fs_cyc, 1);
    chk("restart active_count", int'(active_count), 0);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("restart v%0d act", s), fr_act[s], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
